// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m: SQI SRAM responder sitting behind the SQI pins.
// Decodes READ (0x03) / WRITE (0x02), a 16b big-endian address, then streams
// nibbles in sequential mode. SCK qualifies transfers within the single clock.
// Optional: define IDLI_SQI_MEM_PAGE_WRAP_EN to wrap sequential addressing
// inside a 32-byte page (needs ADDR_W >= 5).
module idli_sqi_mem_m #(
   parameter int ADDR_W = 8
) (
   input  logic       i_mem_gck,
   input  logic       i_mem_rst,
   input  logic       i_mem_sqi_cs,
   input  logic       i_mem_sqi_sck,
   input  logic [3:0] i_mem_sqi_data,
   output logic [3:0] o_mem_sqi_data,
   output logic       o_mem_sqi_oe
);

   typedef enum logic [2:0] {
      S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_IGNORE
   } state_t;

   state_t            state;
   logic [1:0]        cnt;
   logic              is_rd;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_inc;
   logic              ptr_lo;   // 0: high nibble next, 1: low nibble next
   logic [11:0]       sh;       // instruction/address shifter; sh[3:0] doubles as write holding nibble
   logic [7:0]        mem [2**ADDR_W];
   logic              step;
   logic              wr_en;
   logic [15:0]       addr_full;
   logic [7:0]        rd_byte;
   logic              addr_hi_unused;

   assign step      = ~i_mem_sqi_cs & i_mem_sqi_sck;
   assign addr_full = {sh, i_mem_sqi_data};
   assign wr_en     = ~i_mem_rst & step & (state == S_WDATA) & ptr_lo;

   // Upper address bits beyond the implemented array are ignored.
   assign addr_hi_unused = ^addr_full;

`ifdef IDLI_SQI_MEM_PAGE_WRAP_EN
   if (ADDR_W < 5) begin : g_page_chk
      $error("IDLI_SQI_MEM_PAGE_WRAP_EN needs ADDR_W >= 5");
   end
   if (ADDR_W > 5) begin : g_page_inc
      assign addr_inc = {addr[ADDR_W-1:5], addr[4:0] + 5'd1};
   end else begin : g_small_inc
      assign addr_inc = addr + ADDR_W'(1);
   end
`else
   assign addr_inc = addr + ADDR_W'(1);
`endif

   // Read path is combinational from the registered address and pointer.
   assign rd_byte        = mem[addr];
   assign o_mem_sqi_oe   = (state == S_RDATA) & ~i_mem_sqi_cs;
   assign o_mem_sqi_data = o_mem_sqi_oe ? (ptr_lo ? rd_byte[3:0] : rd_byte[7:4]) : 4'h0;

   // Storage array: not reset, written on the low-nibble step of a write.
   always_ff @(posedge i_mem_gck) begin
      if (wr_en) mem[addr] <= {sh[3:0], i_mem_sqi_data};
   end

   // Transaction FSM: cs high aborts, steps advance, sck low holds.
   always_ff @(posedge i_mem_gck) begin
      if (i_mem_rst) begin
         state  <= S_CMD;
         cnt    <= 2'd0;
         is_rd  <= 1'b0;
         addr   <= '0;
         ptr_lo <= 1'b0;
         sh     <= '0;
      end else if (i_mem_sqi_cs) begin
         state <= S_CMD;
         cnt   <= 2'd0;
      end else if (i_mem_sqi_sck) begin
         case (state)
            S_CMD: begin
               sh <= {sh[7:0], i_mem_sqi_data};
               if (cnt == 2'd1) begin
                  cnt <= 2'd0;
                  case (addr_full[7:0])
                     8'h03:   begin state <= S_ADDR; is_rd <= 1'b1; end
                     8'h02:   begin state <= S_ADDR; is_rd <= 1'b0; end
                     default: state <= S_IGNORE;
                  endcase
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            S_ADDR: begin
               sh <= {sh[7:0], i_mem_sqi_data};
               if (cnt == 2'd3) begin
                  cnt    <= 2'd0;
                  addr   <= addr_full[ADDR_W-1:0];
                  ptr_lo <= 1'b0;
                  state  <= is_rd ? S_DUMMY : S_WDATA;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            S_DUMMY: begin
               if (cnt == 2'd1) begin
                  cnt   <= 2'd0;
                  state <= S_RDATA;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            S_WDATA: begin
               if (!ptr_lo) begin
                  sh     <= {sh[7:0], i_mem_sqi_data};
                  ptr_lo <= 1'b1;
               end else begin
                  addr   <= addr_inc;
                  ptr_lo <= 1'b0;
               end
            end
            S_RDATA: begin
               if (ptr_lo) addr <= addr_inc;
               ptr_lo <= ~ptr_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Bench for idli_sqi_mem_m: directed scenarios plus randomized write/read
// transactions checked against a byte-array model of the memory.
module tb_idli_sqi_mem_m;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic       gck = 1'b0;
   logic       rst, cs, sck;
   logic [3:0] din, dout;
   logic       oe;
   int         passed = 0;
   int         total  = 0;
   int         fails  = 0;
   logic [7:0] mdl [DEPTH];

   always #5 gck = ~gck;

   idli_sqi_mem_m #(.ADDR_W(ADDR_W)) dut (
      .i_mem_gck      (gck),
      .i_mem_rst      (rst),
      .i_mem_sqi_cs   (cs),
      .i_mem_sqi_sck  (sck),
      .i_mem_sqi_data (din),
      .o_mem_sqi_data (dout),
      .o_mem_sqi_oe   (oe)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge with the given pins; returns #1 after the rising edge.
   task automatic cyc(input logic c, input logic s, input logic [3:0] d);
      @(negedge gck);
      cs = c; sck = s; din = d;
      @(posedge gck);
      #1;
   endtask

   task automatic stp(input logic [3:0] d);
      cyc(1'b0, 1'b1, d);
   endtask

   task automatic maybe_stall();
      if ($urandom_range(3) == 0) cyc(1'b0, 1'b0, 4'($urandom));
   endtask

   task automatic hdr(input logic [7:0] op, input logic [15:0] a);
      stp(op[7:4]);   stp(op[3:0]);
      stp(a[15:12]);  stp(a[11:8]);
      stp(a[7:4]);    stp(a[3:0]);
   endtask

   function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a);
`ifdef IDLI_SQI_MEM_PAGE_WRAP_EN
      return {a[ADDR_W-1:5], a[4:0] + 5'd1};
`else
      return a + ADDR_W'(1);
`endif
   endfunction

   task automatic write_bytes(input logic [15:0] a16, input logic [7:0] q[$]);
      logic [ADDR_W-1:0] a;
      a = a16[ADDR_W-1:0];
      hdr(8'h02, a16);
      foreach (q[i]) begin
         maybe_stall();
         stp(q[i][7:4]);
         maybe_stall();
         stp(q[i][3:0]);
         mdl[a] = q[i];
         a = nxt(a);
      end
      cyc(1'b1, 1'b0, 4'h0);
   endtask

   task automatic read_check(input logic [15:0] a16, input int n);
      logic [ADDR_W-1:0] a;
      logic [7:0]        b;
      a = a16[ADDR_W-1:0];
      hdr(8'h03, a16);
      stp(4'($urandom)); stp(4'($urandom));
      for (int i = 0; i < n; i++) begin
         b = mdl[a];
         for (int h = 0; h < 2; h++) begin
            maybe_stall();
            chk("rd_oe", 8'(oe), 8'h01);
            chk("rd_data", 8'(dout), (h == 0) ? 8'(b[7:4]) : 8'(b[3:0]));
            stp(4'($urandom));
         end
         a = nxt(a);
      end
      cyc(1'b1, 1'b0, 4'h0);
      chk("rd_oe_off", 8'(oe), 8'h00);
   endtask

   task automatic rd_byte(input logic [15:0] a16, output logic [7:0] b);
      hdr(8'h03, a16);
      stp(4'h0); stp(4'h0);
      b[7:4] = dout; stp(4'h0);
      b[3:0] = dout; stp(4'h0);
      cyc(1'b1, 1'b0, 4'h0);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] b;
      logic [15:0] ra;
      rst = 1'b1; cs = 1'b1; sck = 1'b0; din = 4'h0;
      cyc(1'b1, 1'b0, 4'h0);
      cyc(1'b0, 1'b1, 4'h5);
      chk("rst_oe", 8'(oe), 8'h00);
      chk("rst_data", 8'(dout), 8'h00);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 4'h0);

      // Fill the whole array in 32-byte pages so the model is fully known.
      for (int p = 0; p < DEPTH / 32; p++) begin
         q.delete();
         for (int i = 0; i < 32; i++) q.push_back(8'($urandom));
         write_bytes(16'(p * 32), q);
      end

      // Write A5 3C at 0x10, then read back with a stall on the first nibble.
      write_bytes(16'h0010, '{8'hA5, 8'h3C});
      hdr(8'h03, 16'h0010);
      stp(4'h0); stp(4'h0);
      chk("wr_rd_oe", 8'(oe), 8'h01);
      chk("wr_rd_n0", 8'(dout), 8'h0A);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 4'($urandom));
         chk("stall_hold", 8'(dout), 8'h0A);
      end
      stp(4'h0); chk("wr_rd_n1", 8'(dout), 8'h05);
      stp(4'h0); chk("wr_rd_n2", 8'(dout), 8'h03);
      stp(4'h0); chk("wr_rd_n3", 8'(dout), 8'h0C);
      cyc(1'b1, 1'b0, 4'h0);

      // Address wrap.
`ifdef IDLI_SQI_MEM_PAGE_WRAP_EN
      write_bytes(16'h003F, '{8'h11, 8'h22});
      rd_byte(16'h003F, b); chk("wrap_first", b, 8'h11);
      rd_byte(16'h0020, b); chk("wrap_second", b, 8'h22);
      read_check(16'h003E, 3);
`else
      write_bytes(16'h00FF, '{8'h11, 8'h22});
      rd_byte(16'h00FF, b); chk("wrap_first", b, 8'h11);
      rd_byte(16'h0000, b); chk("wrap_second", b, 8'h22);
      read_check(16'h00FE, 3);
`endif

      // Bad instruction: bus never driven, array untouched.
      stp(4'h0); stp(4'h7);
      for (int i = 0; i < 8; i++) begin
         stp(4'($urandom));
         chk("bad_oe", 8'(oe), 8'h00);
      end
      cyc(1'b1, 1'b0, 4'h0);
      rd_byte(16'h0010, b); chk("bad_after", b, 8'hA5);
      read_check(16'h0000, 32);

      // Abort a write after only the high nibble.
      write_bytes(16'h0040, '{8'h99});
      hdr(8'h02, 16'h0040);
      stp(4'h7);
      cyc(1'b1, 1'b0, 4'h0);
      rd_byte(16'h0040, b); chk("abort_keep", b, 8'h99);

      // Reset in the middle of a read.
      hdr(8'h03, 16'h0010);
      stp(4'h0); stp(4'h0);
      chk("mid_rd_oe", 8'(oe), 8'h01);
      stp(4'h0);
      rst = 1'b1;
      cyc(1'b0, 1'b1, 4'h0);
      chk("mid_rst_oe", 8'(oe), 8'h00);
      chk("mid_rst_data", 8'(dout), 8'h00);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 4'h0);
      rd_byte(16'h0010, b); chk("rst_retain", b, 8'hA5);

      // Randomized traffic; upper address bits are random and must be ignored.
      for (int it = 0; it < 30; it++) begin
         q.delete();
         for (int i = 0; i < int'($urandom_range(1, 4)); i++) q.push_back(8'($urandom));
         ra = 16'($urandom);
         write_bytes(ra, q);
         read_check(ra, q.size());
         read_check(16'($urandom), int'($urandom_range(1, 4)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
